// File: rtl/prod_mem_pkg.sv
// Shared types and sizing for the product memory writer/reader pair.
package prod_mem_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 62;

  typedef enum logic [1:0] {IDLE, READ, DONE} rd_state_t;
endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO used as the output skid buffer; head is the oldest word.
module skid_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= data;
          else             tail <= data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands where the queue tail will be.
          if (occ == 2'd1) begin
            head <= data;
          end else begin
            head <= tail;
            tail <= data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/prod_block_reader.sv
// Block reader for the product memory: issues reads 0..len-1 and streams
// the returned words through a skid buffer on a valid/ready interface.
module prod_block_reader
  import prod_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_blockRead,
  input  logic [6:0]        rd_count,
  output logic              RDY_blockRead,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  input  logic [DATA_W-1:0] readMem_val,
  output logic              VALID_memVal,
  output logic [DATA_W-1:0] memVal_data,
  input  logic              memVal_ready,
  output logic              DONE_blockRead
);
  rd_state_t         state;
  logic [6:0]        len;
  logic [6:0]        sent;
  logic [ADDR_W-1:0] addr;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic              pop;
  logic              push;
  logic              issue;

  // A read is only issued if its data is guaranteed a buffer slot on return.
  always_comb begin
    pop   = VALID_memVal & memVal_ready;
    push  = (state == READ) & inflight;
    issue = (state == READ) && ({1'b0, addr} < len) &&
            (({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  end

  assign EN_readMem   = issue;
  assign readMem_addr = issue ? addr : '0;
  assign VALID_memVal = (occ != 2'd0);
  assign memVal_data  = VALID_memVal ? head : '0;

  skid_fifo2 #(.W(DATA_W)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .data (readMem_val),
    .occ  (occ),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      RDY_blockRead  <= 1'b1;
      DONE_blockRead <= 1'b0;
      len            <= '0;
      sent           <= '0;
      addr           <= '0;
      inflight       <= 1'b0;
    end else begin
      inflight       <= issue;
      DONE_blockRead <= 1'b0;
      unique case (state)
        IDLE: begin
          if (EN_blockRead) begin
            len           <= (rd_count > 7'(DEPTH)) ? 7'(DEPTH) : rd_count;
            addr          <= '0;
            sent          <= '0;
            RDY_blockRead <= 1'b0;
            if (rd_count == 7'd0) begin
              state          <= DONE;
              DONE_blockRead <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (issue) addr <= addr + ADDR_W'(1);
          if (pop) begin
            sent <= sent + 7'd1;
            if (sent + 7'd1 == len) begin
              state          <= DONE;
              DONE_blockRead <= 1'b1;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          RDY_blockRead <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prod_block_reader.sv
// Self-checking bench for prod_block_reader: memory model mem[a]=a*3+1,
// expected stream derived from request length and address order.
module tb_prod_block_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        EN_blockRead;
  logic [6:0]  rd_count;
  logic        RDY_blockRead;
  logic        EN_readMem;
  logic [5:0]  readMem_addr;
  logic [31:0] readMem_val = '0;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        memVal_ready;
  logic        DONE_blockRead;

  prod_block_reader dut (
    .clk            (clk),
    .rst            (rst),
    .EN_blockRead   (EN_blockRead),
    .rd_count       (rd_count),
    .RDY_blockRead  (RDY_blockRead),
    .EN_readMem     (EN_readMem),
    .readMem_addr   (readMem_addr),
    .readMem_val    (readMem_val),
    .VALID_memVal   (VALID_memVal),
    .memVal_data    (memVal_data),
    .memVal_ready   (memVal_ready),
    .DONE_blockRead (DONE_blockRead)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    readMem_val <= EN_readMem ? ({26'b0, readMem_addr} * 32'd3 + 32'd1) : $urandom;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model of the block in progress
  bit   active = 0;
  bit   block_done = 0;
  int   exp_len = 0;
  int   issue_n = 0;
  int   xfer_n = 0;
  int   start_cyc = 0;
  int   first_en = -1;
  int   first_valid = -1;
  int   done_rel = -1;
  int   last_xfer_rel = 0;
  int   last_addr = -1;
  int   stall_cycles = 0;
  int   done_cnt = 0;
  int   max_out = 0;
  bit   prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic [31:0] last_data = '0;
  int   rmode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready pattern generator: 0 always high, 1 toggle, 2 random, 3 low in cycles 3..9.
  initial begin
    memVal_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: memVal_ready = 1'b1;
        1: memVal_ready = ~memVal_ready;
        2: memVal_ready = 1'($urandom_range(0, 1));
        default: memVal_ready = !((cyc - start_cyc) >= 3 && (cyc - start_cyc) <= 9);
      endcase
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    int rel;
    if (!rst) begin
      active     = 0;
      prev_stall = 0;
    end else begin
      rel = cyc - start_cyc;
      if (EN_readMem) begin
        check("issue_in_block", active && issue_n < exp_len, 1);
        check("issue_addr", readMem_addr, issue_n);
        check("outstanding", (issue_n - xfer_n) <= 3, 1);
        if (issue_n - xfer_n > max_out) max_out = issue_n - xfer_n;
        if (first_en < 0) first_en = rel;
        last_addr = readMem_addr;
        issue_n++;
      end
      if (prev_stall) begin
        check("valid_held", VALID_memVal, 1);
        check("data_held", memVal_data, prev_data);
      end
      if (VALID_memVal) begin
        check("valid_in_block", active && xfer_n < exp_len, 1);
        check("data_order", memVal_data, xfer_n * 3 + 1);
        if (first_valid < 0) first_valid = rel;
      end
      prev_stall = VALID_memVal && !memVal_ready;
      prev_data  = memVal_data;
      if (prev_stall) stall_cycles++;
      if (VALID_memVal && memVal_ready) begin
        last_data     = memVal_data;
        last_xfer_rel = rel;
        xfer_n++;
      end
      if (DONE_blockRead) begin
        check("done_in_block", active, 1);
        check("done_xfer_count", xfer_n, exp_len);
        check("done_issue_count", issue_n, exp_len);
        check("done_timing", rel, (exp_len == 0) ? 1 : last_xfer_rel + 1);
        done_rel   = rel;
        done_cnt++;
        active     = 0;
        block_done = 1;
      end
      if (RDY_blockRead && EN_blockRead) begin
        check("start_when_idle", active, 0);
        active       = 1;
        block_done   = 0;
        exp_len      = (rd_count > 7'd62) ? 62 : int'(rd_count);
        issue_n      = 0;
        xfer_n       = 0;
        start_cyc    = cyc;
        first_en     = -1;
        first_valid  = -1;
        done_rel     = -1;
        last_addr    = -1;
        stall_cycles = 0;
        max_out      = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!RDY_blockRead && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", RDY_blockRead, 1);
  endtask

  task automatic start_block(input int n);
    EN_blockRead = 1'b1;
    rd_count     = 7'(n);
    step();
    EN_blockRead = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!block_done && n < budget) begin
      step();
      n++;
    end
    check("done_within_budget", block_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int snap;
    rst = 1'b0;
    EN_blockRead = 1'b0;
    rd_count = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_rdy", RDY_blockRead, 1);
    check("reset_en_read", EN_readMem, 0);
    check("reset_valid", VALID_memVal, 0);
    check("reset_done", DONE_blockRead, 0);
    step();
    rst = 1'b1;
    step();

    // 1: five words, ready high
    rmode = 0;
    wait_idle(20);
    start_block(5);
    wait_done(50);
    check("t1_first_en", first_en, 1);
    check("t1_first_valid", first_valid, 3);
    check("t1_done_cycle", done_rel, 8);
    check("t1_last_addr", last_addr, 4);
    check("t1_last_data", last_data, 13);

    // 2: empty block
    wait_idle(20);
    start_block(0);
    wait_done(20);
    check("t2_done_cycle", done_rel, 1);
    check("t2_no_reads", issue_n, 0);
    check("t2_rdy_cycle2", RDY_blockRead, 1);

    // 3: backpressure window
    rmode = 3;
    wait_idle(20);
    start_block(8);
    wait_done(100);
    check("t3_all_arrived", xfer_n, 8);
    check("t3_stalled", stall_cycles >= 7, 1);
    check("t3_max_outstanding", max_out <= 3, 1);

    // 4: clamped request
    rmode = 0;
    wait_idle(20);
    start_block(70);
    wait_done(200);
    check("t4_clamped_len", xfer_n, 62);
    check("t4_last_addr", last_addr, 61);
    check("t4_last_data", last_data, 184);

    // 5: start pulse while busy must be ignored
    wait_idle(20);
    start_block(10);
    repeat (3) step();
    EN_blockRead = 1'b1;
    rd_count = 7'd3;
    step();
    EN_blockRead = 1'b0;
    wait_done(100);
    check("t5_len_unchanged", xfer_n, 10);

    // 6: reset mid-block
    wait_idle(20);
    start_block(6);
    n = 0;
    while (xfer_n < 3 && n < 50) begin
      step();
      n++;
    end
    check("t6_reached_third", xfer_n, 3);
    snap = done_cnt;
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rdy", RDY_blockRead, 1);
    check("t6_en_read", EN_readMem, 0);
    check("t6_addr", readMem_addr, 0);
    check("t6_valid", VALID_memVal, 0);
    check("t6_data", memVal_data, 0);
    check("t6_done", DONE_blockRead, 0);
    repeat (5) step();
    check("t6_no_done_pulse", done_cnt, snap);
    start_block(2);
    wait_done(50);
    check("t6_restart_count", xfer_n, 2);
    check("t6_restart_last", last_data, 4);

    // 7: full block with toggling ready
    rmode = 1;
    wait_idle(20);
    start_block(62);
    wait_done(400);
    check("t7_count", xfer_n, 62);
    check("t7_last_data", last_data, 184);

    // Random blocks with random ready
    rmode = 2;
    for (int i = 0; i < 8; i++) begin
      wait_idle(20);
      start_block(int'($urandom_range(0, 80)));
      wait_done(600);
      check("rand_count", xfer_n, exp_len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
